if_pc_fetch: RTL and testbench

//  Fetch stage front end of the MIPS core: owns the PC register and issues instruction reads on the sram-like inst port.

---
 rtl/if_pc_fetch_pkg.sv | 19 +
 rtl/if_pc_fetch_if.sv | 42 ++++
 rtl/if_pc_fetch_add_32.sv | 10 +
 rtl/if_pc_fetch.sv | 144 ++++++++++++++
 tb/tb_if_pc_fetch.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pc_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   - RESET_PC_DEF    : default boot address (uncached kseg1 boot ROM)
//   - fetch_state_t   : fetch FSM encoding (REQ=0, WAIT=1, HOLD=2)
//   - pc_misaligned() : word-alignment test used to raise the fetch address error
package if_pc_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,  // issue (or try to issue) a request for pc
        ST_WAIT = 2'd1,  // request accepted, waiting for read data
        ST_HOLD = 2'd2   // instruction held for decode
    } fetch_state_t;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_pc_fetch_if.sv
// Bus bundle for the fetch stage: the sram-like instruction port plus the
// fetch-to-decode handoff.
//   master : fetch stage (drives request and fs_* outputs)
//   slave  : memory + decode side (drives addr_ok/data_ok/rdata and ds_allowin)
//
// Handshake rules:
//   inst port  - a request is accepted in a cycle where inst_req & inst_addr_ok;
//                inst_addr stays put while inst_req=1 and addr_ok=0 unless a
//                redirect occurs. inst_data_ok returns one word per accepted
//                request; at most one request is outstanding.
//   decode     - fs_valid & ds_allowin in the same cycle transfers {fs_pc,
//                fs_inst, fs_adel}; while fs_valid=1 and ds_allowin=0 those
//                outputs are held stable.
interface if_pc_fetch_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        ds_allowin;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        fs_adel;

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  ds_allowin,
        output fs_valid, fs_pc, fs_inst, fs_adel
    );

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output ds_allowin,
        input  fs_valid, fs_pc, fs_inst, fs_adel
    );
endinterface

// File: rtl/if_pc_fetch_add_32.sv
// 32-bit adder used for the sequential PC increment.
//   a, b : operands
//   y    : a + b, modulo 2^32 (carry out discarded so 0xFFFF_FFFC + 4 wraps to 0)
module add_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a + b;
endmodule

// File: rtl/if_pc_fetch.sv
// Fetch stage front end: owns the PC, issues word reads on the sram-like
// instruction port and hands {pc, inst, adel} to decode.
//   clk, resetn            : clock, asynchronous active-low reset
//   br_redirect, br_target : taken branch/jump from decode
//   ex_flush, ex_target    : exception/eret flush from writeback (wins over branch)
//   bus (master)           : instruction port + decode handoff
//   dbg_state              : current fetch FSM state
module if_pc_fetch
    import if_pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          br_redirect,
    input  logic [31:0]   br_target,
    input  logic          ex_flush,
    input  logic [31:0]   ex_target,
    if_pc_fetch_if.master bus,
    output fetch_state_t  dbg_state
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         cancel_q, cancel_d;
    logic [31:0]  fs_pc_q, fs_pc_d;
    logic [31:0]  fs_inst_q, fs_inst_d;
    logic         fs_adel_q, fs_adel_d;

    logic [31:0]  seq_pc;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         misaligned;
    logic         inst_req;
    logic         accept;

    add_32 u_pc_inc (
        .a (pc_q),
        .b (32'd4),
        .y (seq_pc)
    );

    assign redirect    = ex_flush | br_redirect;
    assign redirect_pc = ex_flush ? ex_target : br_target;
    assign misaligned  = pc_misaligned(pc_q);

    // A redirect suppresses the request in the same cycle so the memory is
    // never handed an address that is about to be abandoned. Gating with
    // resetn keeps the request low while reset is held.
    assign inst_req = resetn && (state_q == ST_REQ) && !misaligned && !redirect;
    assign accept   = inst_req && bus.inst_addr_ok;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        cancel_d  = cancel_q;
        fs_pc_d   = fs_pc_q;
        fs_inst_d = fs_inst_q;
        fs_adel_d = fs_adel_q;

        unique case (state_q)
            ST_REQ: begin
                if (accept) begin
                    state_d  = ST_WAIT;
                    req_pc_d = pc_q;
                    pc_d     = seq_pc;
                    cancel_d = 1'b0;
                end else if (misaligned && !redirect) begin
                    // Unfetchable address: present it to decode as an
                    // address-error slot with fs_pc carrying BadVAddr.
                    state_d   = ST_HOLD;
                    fs_adel_d = 1'b1;
                    fs_inst_d = NOP_INST;
                    fs_pc_d   = pc_q;
                end
            end
            ST_WAIT: begin
                if (bus.inst_data_ok) begin
                    if (cancel_q || redirect) begin
                        // Stale response: drop it and fetch from the new PC.
                        state_d  = ST_REQ;
                        cancel_d = 1'b0;
                    end else begin
                        state_d   = ST_HOLD;
                        fs_inst_d = bus.inst_rdata;
                        fs_pc_d   = req_pc_q;
                        fs_adel_d = 1'b0;
                    end
                end else if (redirect) begin
                    // Response still owed by memory; remember to discard it.
                    cancel_d = 1'b1;
                end
            end
            ST_HOLD: begin
                // A flush discards the held slot even if decode is stalled.
                if (redirect || bus.ds_allowin) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase

        // Redirect target always wins over the sequential increment.
        if (redirect) begin
            pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            req_pc_q  <= RESET_PC;
            cancel_q  <= 1'b0;
            fs_pc_q   <= RESET_PC;
            fs_inst_q <= 32'h0000_0000;
            fs_adel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            cancel_q  <= cancel_d;
            fs_pc_q   <= fs_pc_d;
            fs_inst_q <= fs_inst_d;
            fs_adel_q <= fs_adel_d;
        end
    end

    assign bus.inst_req  = inst_req;
    assign bus.inst_wr   = 1'b0;
    assign bus.inst_size = 2'b10;
    assign bus.inst_addr = pc_q;
    assign bus.fs_valid  = (state_q == ST_HOLD);
    assign bus.fs_pc     = fs_pc_q;
    assign bus.fs_inst   = fs_inst_q;
    assign bus.fs_adel   = fs_adel_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_if_pc_fetch.sv
// Directed bench for if_pc_fetch. A small memory model accepts every request
// (addr_ok=1) and returns data one cycle later unless mem_stall holds it back.
// Inputs change 1 time unit after the rising edge; checks run 2 units after it.
module tb_if_pc_fetch;
    import if_pc_fetch_pkg::*;

    logic         clk;
    logic         resetn;
    logic         br_redirect;
    logic [31:0]  br_target;
    logic         ex_flush;
    logic [31:0]  ex_target;
    fetch_state_t dbg_state;

    if_pc_fetch_if bus ();

    if_pc_fetch dut (
        .clk         (clk),
        .resetn      (resetn),
        .br_redirect (br_redirect),
        .br_target   (br_target),
        .ex_flush    (ex_flush),
        .ex_target   (ex_target),
        .bus         (bus),
        .dbg_state   (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // memory model state
    logic        mem_pend;
    logic [31:0] mem_data;
    logic        mem_stall;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h2408_0001;
        return a + 32'h1000_0000;
    endfunction

    // Close the current cycle: latch any accepted request into the memory,
    // advance one clock and present the memory response for the new cycle.
    task automatic cyc();
        if (!resetn) begin
            mem_pend = 1'b0;
        end else begin
            if (bus.inst_data_ok) mem_pend = 1'b0;
            if (bus.inst_req && bus.inst_addr_ok) begin
                mem_pend = 1'b1;
                mem_data = mem_word(bus.inst_addr);
            end
        end
        @(posedge clk);
        #1;
        if (!resetn) mem_pend = 1'b0;
        bus.inst_data_ok = mem_pend && !mem_stall;
        bus.inst_rdata   = bus.inst_data_ok ? mem_data : 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (bus.inst_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_inst_req: got %b expected 0", bus.inst_req);
        end
        n_checks++;
        if (bus.fs_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_fs_valid: got %b expected 0", bus.fs_valid);
        end
        n_checks++;
        if (bus.fs_pc !== 32'hBFC0_0000) begin
            n_fail++; $display("FAIL reset_fs_pc: got %h expected bfc00000", bus.fs_pc);
        end
        n_checks++;
        if (bus.fs_inst !== 32'h0 || bus.fs_adel !== 1'b0) begin
            n_fail++; $display("FAIL reset_fs_inst_adel: got %h/%b expected 00000000/0", bus.fs_inst, bus.fs_adel);
        end
        n_checks++;
        if (dbg_state !== ST_REQ || bus.inst_wr !== 1'b0 || bus.inst_size !== 2'b10) begin
            n_fail++; $display("FAIL reset_state_tieoffs: got %0d/%b/%b expected 0/0/10", dbg_state, bus.inst_wr, bus.inst_size);
        end
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_basic_fetch();
        bus.ds_allowin = 1'b1;
        n_checks++;
        if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0000) begin
            n_fail++; $display("FAIL basic_first_req: got %b/%h expected 1/bfc00000", bus.inst_req, bus.inst_addr);
        end
        cyc();  // WAIT, data_ok this cycle
        n_checks++;
        if (bus.inst_req !== 1'b0 || bus.fs_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_wait: got req=%b valid=%b expected 0/0", bus.inst_req, bus.fs_valid);
        end
        cyc();  // HOLD
        n_checks++;
        if (bus.fs_valid !== 1'b1 || bus.fs_pc !== 32'hBFC0_0000 || bus.fs_inst !== 32'h2408_0001) begin
            n_fail++; $display("FAIL basic_deliver: got %b/%h/%h expected 1/bfc00000/24080001", bus.fs_valid, bus.fs_pc, bus.fs_inst);
        end
        cyc();  // back to REQ
        n_checks++;
        if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0004) begin
            n_fail++; $display("FAIL basic_next_req: got %b/%h expected 1/bfc00004", bus.inst_req, bus.inst_addr);
        end
    endtask

    task automatic test_hold_stall();
        bus.ds_allowin = 1'b0;
        cyc();  // WAIT
        cyc();  // HOLD with 0xBFC00004
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.fs_valid !== 1'b1 || bus.fs_pc !== 32'hBFC0_0004 ||
                bus.fs_inst !== 32'hCFC0_0004 || bus.inst_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got %b/%h/%h req=%b expected 1/bfc00004/cfc00004 req=0",
                         i, bus.fs_valid, bus.fs_pc, bus.fs_inst, bus.inst_req);
            end
            cyc();
        end
        n_checks++;
        if (bus.fs_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_still_held: got %b expected 1", bus.fs_valid);
        end
        bus.ds_allowin = 1'b1;
        cyc();
        n_checks++;
        if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0008 || bus.fs_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_release: got %b/%h valid=%b expected 1/bfc00008 valid=0", bus.inst_req, bus.inst_addr, bus.fs_valid);
        end
    endtask

    task automatic test_branch_in_wait();
        mem_stall = 1'b1;
        cyc();  // WAIT, response held back
        n_checks++;
        if (dbg_state !== ST_WAIT || bus.inst_data_ok !== 1'b0) begin
            n_fail++; $display("FAIL br_wait_state: got %0d/%b expected 1/0", dbg_state, bus.inst_data_ok);
        end
        br_redirect = 1'b1;
        br_target   = 32'hBFC0_0100;
        #1;
        cyc();
        br_redirect = 1'b0;
        mem_stall   = 1'b0;
        #1;
        cyc();  // stale data returns now
        n_checks++;
        if (bus.inst_data_ok !== 1'b1 || bus.fs_valid !== 1'b0 || bus.inst_req !== 1'b0) begin
            n_fail++; $display("FAIL br_stale_data: got dok=%b valid=%b req=%b expected 1/0/0", bus.inst_data_ok, bus.fs_valid, bus.inst_req);
        end
        cyc();
        n_checks++;
        if (bus.fs_valid !== 1'b0 || bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0100) begin
            n_fail++; $display("FAIL br_target_req: got valid=%b %b/%h expected 0 1/bfc00100", bus.fs_valid, bus.inst_req, bus.inst_addr);
        end
    endtask

    task automatic test_flush_priority();
        cyc();  // WAIT, data_ok this cycle
        ex_flush    = 1'b1;
        ex_target   = 32'hBFC0_0380;
        br_redirect = 1'b1;
        br_target   = 32'hBFC0_0200;
        #1;
        cyc();
        ex_flush    = 1'b0;
        br_redirect = 1'b0;
        #1;
        n_checks++;
        if (bus.fs_valid !== 1'b0 || bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0380) begin
            n_fail++; $display("FAIL flush_prio: got valid=%b %b/%h expected 0 1/bfc00380", bus.fs_valid, bus.inst_req, bus.inst_addr);
        end
        // flush while holding and decode stalled
        cyc();  // WAIT
        cyc();  // HOLD
        n_checks++;
        if (bus.fs_valid !== 1'b1 || bus.fs_pc !== 32'hBFC0_0380 || bus.fs_inst !== 32'hCFC0_0380) begin
            n_fail++; $display("FAIL flush_fetch_entry: got %b/%h/%h expected 1/bfc00380/cfc00380", bus.fs_valid, bus.fs_pc, bus.fs_inst);
        end
        bus.ds_allowin = 1'b0;
        ex_flush       = 1'b1;
        ex_target      = 32'hBFC0_0500;
        #1;
        cyc();
        ex_flush = 1'b0;
        #1;
        n_checks++;
        if (bus.fs_valid !== 1'b0 || bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0500) begin
            n_fail++; $display("FAIL flush_in_hold: got valid=%b %b/%h expected 0 1/bfc00500", bus.fs_valid, bus.inst_req, bus.inst_addr);
        end
    endtask

    task automatic test_adel();
        br_redirect = 1'b1;
        br_target   = 32'hBFC0_0102;
        #1;
        n_checks++;
        if (bus.inst_req !== 1'b0) begin
            n_fail++; $display("FAIL adel_req_on_redirect: got %b expected 0", bus.inst_req);
        end
        cyc();
        br_redirect = 1'b0;
        #1;
        n_checks++;
        if (bus.inst_req !== 1'b0 || bus.inst_addr !== 32'hBFC0_0102) begin
            n_fail++; $display("FAIL adel_no_req: got %b/%h expected 0/bfc00102", bus.inst_req, bus.inst_addr);
        end
        cyc();
        n_checks++;
        if (bus.fs_valid !== 1'b1 || bus.fs_adel !== 1'b1 || bus.fs_pc !== 32'hBFC0_0102 ||
            bus.fs_inst !== 32'h0 || bus.inst_req !== 1'b0) begin
            n_fail++; $display("FAIL adel_slot: got %b/%b/%h/%h req=%b expected 1/1/bfc00102/00000000 req=0",
                               bus.fs_valid, bus.fs_adel, bus.fs_pc, bus.fs_inst, bus.inst_req);
        end
    endtask

    task automatic test_wrap_and_reset();
        br_redirect = 1'b1;
        br_target   = 32'hFFFF_FFFC;
        #1;
        cyc();
        br_redirect    = 1'b0;
        bus.ds_allowin = 1'b1;
        #1;
        n_checks++;
        if (bus.fs_valid !== 1'b0 || bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_req: got valid=%b %b/%h expected 0 1/fffffffc", bus.fs_valid, bus.inst_req, bus.inst_addr);
        end
        cyc();  // WAIT
        cyc();  // HOLD
        n_checks++;
        if (bus.fs_valid !== 1'b1 || bus.fs_pc !== 32'hFFFF_FFFC || bus.fs_inst !== 32'h0FFF_FFFC || bus.fs_adel !== 1'b0) begin
            n_fail++; $display("FAIL wrap_deliver: got %b/%h/%h/%b expected 1/fffffffc/0ffffffc/0", bus.fs_valid, bus.fs_pc, bus.fs_inst, bus.fs_adel);
        end
        cyc();
        n_checks++;
        if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h0000_0000) begin
            n_fail++; $display("FAIL wrap_next: got %b/%h expected 1/00000000", bus.inst_req, bus.inst_addr);
        end
        mem_stall = 1'b1;
        cyc();  // WAIT, response pending
        resetn = 1'b0;
        #1;
        n_checks++;
        if (bus.inst_req !== 1'b0 || bus.fs_valid !== 1'b0 || dbg_state !== ST_REQ || bus.inst_addr !== 32'hBFC0_0000) begin
            n_fail++; $display("FAIL midreset_clear: got req=%b valid=%b st=%0d addr=%h expected 0/0/0/bfc00000",
                               bus.inst_req, bus.fs_valid, dbg_state, bus.inst_addr);
        end
        cyc();
        resetn    = 1'b1;
        mem_stall = 1'b0;
        #1;
        n_checks++;
        if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hBFC0_0000 || bus.inst_data_ok !== 1'b0) begin
            n_fail++; $display("FAIL midreset_restart: got %b/%h dok=%b expected 1/bfc00000 dok=0", bus.inst_req, bus.inst_addr, bus.inst_data_ok);
        end
        cyc();
        cyc();
        n_checks++;
        if (bus.fs_valid !== 1'b1 || bus.fs_pc !== 32'hBFC0_0000 || bus.fs_inst !== 32'h2408_0001) begin
            n_fail++; $display("FAIL midreset_refetch: got %b/%h/%h expected 1/bfc00000/24080001", bus.fs_valid, bus.fs_pc, bus.fs_inst);
        end
    endtask

    initial begin
        resetn           = 1'b0;
        br_redirect      = 1'b0;
        br_target        = 32'h0;
        ex_flush         = 1'b0;
        ex_target        = 32'h0;
        bus.inst_addr_ok = 1'b1;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        bus.ds_allowin   = 1'b0;
        mem_pend         = 1'b0;
        mem_data         = 32'h0;
        mem_stall        = 1'b0;

        test_reset();
        test_basic_fetch();
        test_hold_stall();
        test_branch_in_wait();
        test_flush_priority();
        test_adel();
        test_wrap_and_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
